camara_buffer_wr: RTL and testbench
===================================

// Module: camara_buffer_wr
// PURPOSE
//  Downstream of the camera capture stage. Consumes the 16-bit RGB565 pixel stream
//  (pixel_data/pixel_valid/frame_done) and converts each pixel to RGB332.
//  Writes each pixel into a dual-port frame buffer RAM at a linear raster address.
//  Reports per-frame completeness (frame_ok/frame_err) and keeps a frame counter.
//  Runs in the camera pixel clock domain, p_clock.
// PARAMETERS
//  H_RES  160  active pixels per line
//  V_RES  120  active lines per frame
//  AW     15   address width; must satisfy 2**AW >= H_RES*V_RES
// PORTS
//  p_clock      in   1   camera pixel clock, single clock domain
//  rst_n        in   1   reset, asynchronous assert, active-low
//  pixel_data   in   16  RGB565 pixel from the capture stage, valid with pixel_valid
//  pixel_valid  in   1   one-cycle strobe per complete pixel
//  frame_done   in   1   one-cycle pulse at end of frame (vsync rise)
//  mem_we       out  1   frame buffer write enable
//  mem_addr     out  AW  frame buffer write address, y*H_RES+x
//  mem_data     out  8   RGB332 = {pd[15:13], pd[10:8], pd[4:3]}
//  frame_ok     out  1   1-cycle pulse: frame ended with exactly H_RES*V_RES pixels
//  frame_err    out  1   1-cycle pulse: frame ended with a short or long pixel count
//  frame_cnt    out  8   count of completed frames (ok + err), wraps 255->0
// BEHAVIOUR
//  Reset (rst_n=0, async): all outputs 0; state=SYNC; pix_cnt, x, y and ovf cleared.
//  States:
//   SYNC: pixel_valid ignored; frame_done -> CAPTURE. Capture therefore starts only on a frame boundary.
//   CAPTURE: on pixel_valid with pix_cnt < H_RES*V_RES:
//     next cycle mem_we=1, mem_addr=pix_cnt, mem_data=RGB332(pixel_data).
//     pix_cnt+1; x+1; when x==H_RES-1, x->0 and y+1.
//   CAPTURE overflow: pixel_valid with pix_cnt == H_RES*V_RES:
//     pixel is dropped; mem_we stays 0; sticky ovf=1.
//   CAPTURE end of frame: frame_done -> DONE.
//     If pixel_valid and frame_done occur in the same cycle, the pixel is written and counted first.
//   DONE (1 cycle):
//     frame_ok=1 iff pix_cnt==H_RES*V_RES && !ovf; otherwise frame_err=1.
//     frame_cnt+1; pix_cnt, x, y and ovf cleared; -> CAPTURE.
//     pixel_valid in DONE is written as pixel 0 of the new frame:
//     mem_addr=0, then pix_cnt=1, x=1.
//  Latency: pixel_valid@n -> mem_we/addr/data registered @n+1.
//   frame_done@n -> frame_ok/frame_err @n+2.
//  mem_we is a 1-cycle pulse per accepted pixel; mem_addr and mem_data hold their last values otherwise.
//  Back-to-back pixel_valid on consecutive cycles is accepted at full rate. No stalls, no backpressure.
//  Reset mid-frame aborts the frame: no frame_ok/frame_err for that frame, and a new frame_done is needed.
//  Address arithmetic is unsigned with AW bits; pix_cnt never exceeds H_RES*V_RES.
// CONFIGURATION
//  CAM_TEST_PATTERN_EN defined:
//   Adds input port test_en (1 bit, after frame_done).
//   While test_en=1, mem_data is an 8-bar pattern instead of converted camera data.
//   Bar index b = x*8/H_RES; colours in order: FF,FC,1F,1C,E3,E0,03,00.
//   Timing, addressing and counting are unchanged; pixel_valid still paces writes.
//  CAM_TEST_PATTERN_EN undefined:
//   No test_en port; mem_data is always RGB332(pixel_data).
// TESTING (bench: H_RES=4, V_RES=2, AW=3)
//  1. Reset, then 8 pixel_valid with no prior frame_done -> mem_we never 1; frame_ok/frame_err stay 0.
//  2. frame_done, 8 pixels 16'hF800, frame_done:
//     -> writes to addr 0..7 with data E0; frame_ok pulse; frame_cnt=1.
//  3. Frame of 6 pixels then frame_done -> 6 writes; frame_err pulse; frame_ok=0.
//     Frame of 10 pixels -> 8 writes (addr 0..7), 2 dropped; frame_err pulse.
//  4. Pixel 16'h07E0 in the same cycle as frame_done after 7 pixels:
//     -> written at addr 7 with data 1C; frame_ok pulse.
//     Pixel 16'h001F in the DONE cycle -> addr 0, data 03.
//  5. Assert rst_n=0 after 3 pixels -> outputs 0 immediately; no frame pulse;
//     pixels before the next frame_done are ignored.
//  6. [CAM_TEST_PATTERN_EN] test_en=1, 8 pixels -> data FF,FC,1F,1C,E3,E0,03,00 by x
//     (2 bars per column with H_RES=4: x=0..3 -> FF,1F,E3,03), repeated for both rows.

Source files
------------

// File: rtl/camara_buffer_wr.sv
// Camera frame-buffer writer: RGB565 pixel stream -> RGB332 raster writes, with per-frame
// completeness pulses and a frame counter. Optional CAM_TEST_PATTERN_EN adds an 8-bar test pattern.
module camara_buffer_wr #(
    parameter int H_RES = 160,
    parameter int V_RES = 120,
    parameter int AW    = 15
) (
    input  logic          p_clock,
    input  logic          rst_n,
    input  logic [15:0]   pixel_data,
    input  logic          pixel_valid,
    input  logic          frame_done,
`ifdef CAM_TEST_PATTERN_EN
    input  logic          test_en,
`endif
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_data,
    output logic          frame_ok,
    output logic          frame_err,
    output logic [7:0]    frame_cnt
);

    localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
    // y reaches V_RES after the last pixel of a full frame, so it needs one extra code
    localparam int YW = $clog2(V_RES + 1);
    localparam logic [AW:0] TOTAL = (AW + 1)'(H_RES * V_RES);

    typedef enum logic [1:0] {SYNC, CAPTURE, DONE} state_t;

    state_t          state_reg, state_next;
    logic [AW:0]     pix_cnt_reg, pix_cnt_next;
    logic [XW-1:0]   x_reg, x_next;
    logic [YW-1:0]   y_reg, y_next;
    logic            ovf_reg, ovf_next;
    logic            mem_we_next;
    logic [AW-1:0]   mem_addr_next;
    logic [7:0]      mem_data_next;
    logic            frame_ok_next, frame_err_next;
    logic [7:0]      frame_cnt_next;

    logic [AW:0]     base_cnt;
    logic [XW-1:0]   base_x;
    logic [YW-1:0]   base_y;
    logic            accept;

    always_ff @(posedge p_clock or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= SYNC;
            pix_cnt_reg <= '0;
            x_reg       <= '0;
            y_reg       <= '0;
            ovf_reg     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_data    <= '0;
            frame_ok    <= 1'b0;
            frame_err   <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            state_reg   <= state_next;
            pix_cnt_reg <= pix_cnt_next;
            x_reg       <= x_next;
            y_reg       <= y_next;
            ovf_reg     <= ovf_next;
            mem_we      <= mem_we_next;
            mem_addr    <= mem_addr_next;
            mem_data    <= mem_data_next;
            frame_ok    <= frame_ok_next;
            frame_err   <= frame_err_next;
            frame_cnt   <= frame_cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            SYNC:    if (frame_done) state_next = CAPTURE;
            CAPTURE: if (frame_done) state_next = DONE;
            DONE:    state_next = CAPTURE;
            default: state_next = SYNC;
        endcase
    end

`ifdef CAM_TEST_PATTERN_EN
    logic [2:0] bar;
    logic [7:0] bar_colour;
    always_comb begin
        bar = 3'((32'(base_x) * 32'd8) / 32'(H_RES));
        case (bar)
            3'd0:    bar_colour = 8'hFF;
            3'd1:    bar_colour = 8'hFC;
            3'd2:    bar_colour = 8'h1F;
            3'd3:    bar_colour = 8'h1C;
            3'd4:    bar_colour = 8'hE3;
            3'd5:    bar_colour = 8'hE0;
            3'd6:    bar_colour = 8'h03;
            default: bar_colour = 8'h00;
        endcase
    end
`endif

    always_comb begin
        // DONE restarts the frame, so a pixel arriving there lands at address 0
        base_cnt = (state_reg == DONE) ? '0 : pix_cnt_reg;
        base_x   = (state_reg == DONE) ? '0 : x_reg;
        base_y   = (state_reg == DONE) ? '0 : y_reg;
        accept   = pixel_valid &&
                   (((state_reg == CAPTURE) && (pix_cnt_reg < TOTAL)) || (state_reg == DONE));

        pix_cnt_next   = base_cnt;
        x_next         = base_x;
        y_next         = base_y;
        ovf_next       = (state_reg == DONE) ? 1'b0 : ovf_reg;
        mem_we_next    = 1'b0;
        mem_addr_next  = mem_addr;
        mem_data_next  = mem_data;
        frame_ok_next  = 1'b0;
        frame_err_next = 1'b0;
        frame_cnt_next = frame_cnt;

        if (state_reg == DONE) begin
            frame_ok_next  = (pix_cnt_reg == TOTAL) && !ovf_reg;
            frame_err_next = !((pix_cnt_reg == TOTAL) && !ovf_reg);
            frame_cnt_next = frame_cnt + 8'd1;
        end

        if (accept) begin
            mem_we_next   = 1'b1;
            mem_addr_next = base_cnt[AW-1:0];
`ifdef CAM_TEST_PATTERN_EN
            mem_data_next = test_en ? bar_colour
                                    : {pixel_data[15:13], pixel_data[10:8], pixel_data[4:3]};
`else
            mem_data_next = {pixel_data[15:13], pixel_data[10:8], pixel_data[4:3]};
`endif
            pix_cnt_next  = base_cnt + (AW + 1)'(1);
            if (base_x == XW'(H_RES - 1)) begin
                x_next = '0;
                y_next = base_y + YW'(1);
            end else begin
                x_next = base_x + XW'(1);
            end
        end else if (pixel_valid && (state_reg == CAPTURE)) begin
            ovf_next = 1'b1;
        end
    end

endmodule

// File: tb/tb_camara_buffer_wr.sv
// Directed bench for camara_buffer_wr with a 4x2 frame: sync gating, full/short/long frames,
// coincident pixel+frame_done, async reset abort, and (when enabled) the bar test pattern.
module tb_camara_buffer_wr;

    logic        p_clock = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] pixel_data = '0;
    logic        pixel_valid = 1'b0;
    logic        frame_done = 1'b0;
`ifdef CAM_TEST_PATTERN_EN
    logic        test_en = 1'b0;
`endif
    logic        mem_we;
    logic [2:0]  mem_addr;
    logic [7:0]  mem_data;
    logic        frame_ok, frame_err;
    logic [7:0]  frame_cnt;

    int vectors = 0;
    int miscompares = 0;

    camara_buffer_wr #(.H_RES(4), .V_RES(2), .AW(3)) dut (
        .p_clock    (p_clock),
        .rst_n      (rst_n),
        .pixel_data (pixel_data),
        .pixel_valid(pixel_valid),
        .frame_done (frame_done),
`ifdef CAM_TEST_PATTERN_EN
        .test_en    (test_en),
`endif
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .frame_ok   (frame_ok),
        .frame_err  (frame_err),
        .frame_cnt  (frame_cnt)
    );

    always #5 p_clock = ~p_clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one clock: drive at negedge, return 1 time unit after the capturing posedge
    task automatic cyc(input logic v, input logic [15:0] d, input logic fd);
        @(negedge p_clock);
        pixel_valid = v;
        pixel_data  = d;
        frame_done  = fd;
        @(posedge p_clock);
        #1;
    endtask

    task automatic chk_write(input string tag, input logic [2:0] a, input logic [7:0] d);
        chk({tag, "_we"}, 32'(mem_we), 32'd1);
        chk({tag, "_addr"}, 32'(mem_addr), 32'(a));
        chk({tag, "_data"}, 32'(mem_data), 32'(d));
    endtask

    initial begin
        // 1: reset state, then pixels with no frame boundary are ignored
        cyc(0, 16'h0, 0);
        cyc(0, 16'h0, 0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_data", 32'(mem_data), 32'd0);
        chk("rst_ok", 32'(frame_ok), 32'd0);
        chk("rst_err", 32'(frame_err), 32'd0);
        chk("rst_cnt", 32'(frame_cnt), 32'd0);
        @(negedge p_clock);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc(1, 16'hF800, 0);
            chk("sync_we", 32'(mem_we), 32'd0);
            chk("sync_okerr", 32'({frame_ok, frame_err}), 32'd0);
        end

        // 2: full frame of red pixels
        cyc(0, 16'h0, 1);
        chk("sof_we", 32'(mem_we), 32'd0);
        for (int i = 0; i < 8; i++) begin
            cyc(1, 16'hF800, 0);
            chk_write("full", 3'(i), 8'hE0);
        end
        cyc(0, 16'h0, 1);
        chk("full_we_idle", 32'(mem_we), 32'd0);
        chk("full_ok_early", 32'(frame_ok), 32'd0);
        cyc(0, 16'h0, 0);
        chk("full_ok", 32'(frame_ok), 32'd1);
        chk("full_err", 32'(frame_err), 32'd0);
        chk("full_cnt", 32'(frame_cnt), 32'd1);
        cyc(0, 16'h0, 0);
        chk("full_ok_pulse", 32'(frame_ok), 32'd0);

        // 3a: short frame of 6 pixels
        for (int i = 0; i < 6; i++) begin
            cyc(1, 16'hFFFF, 0);
            chk_write("short", 3'(i), 8'hFF);
        end
        cyc(0, 16'h0, 1);
        cyc(0, 16'h0, 0);
        chk("short_err", 32'(frame_err), 32'd1);
        chk("short_ok", 32'(frame_ok), 32'd0);
        chk("short_cnt", 32'(frame_cnt), 32'd2);

        // 3b: long frame of 10 pixels, last two dropped
        for (int i = 0; i < 10; i++) begin
            cyc(1, 16'h07E0, 0);
            if (i < 8) begin
                chk_write("long", 3'(i), 8'h1C);
            end else begin
                chk("long_drop_we", 32'(mem_we), 32'd0);
                chk("long_drop_addr", 32'(mem_addr), 32'd7);
            end
        end
        cyc(0, 16'h0, 1);
        cyc(0, 16'h0, 0);
        chk("long_err", 32'(frame_err), 32'd1);
        chk("long_ok", 32'(frame_ok), 32'd0);
        chk("long_cnt", 32'(frame_cnt), 32'd3);

        // 4: eighth pixel coincides with frame_done, then a pixel in the DONE cycle
        for (int i = 0; i < 7; i++) cyc(1, 16'h0000, 0);
        chk_write("pre7", 3'd6, 8'h00);
        cyc(1, 16'h07E0, 1);
        chk_write("coinc", 3'd7, 8'h1C);
        cyc(1, 16'h001F, 0);
        chk("coinc_ok", 32'(frame_ok), 32'd1);
        chk("coinc_cnt", 32'(frame_cnt), 32'd4);
        chk_write("done_px", 3'd0, 8'h03);
        for (int i = 1; i < 8; i++) begin
            cyc(1, 16'hF800, 0);
            chk_write("after_done", 3'(i), 8'hE0);
        end
        cyc(0, 16'h0, 1);
        cyc(0, 16'h0, 0);
        chk("done_px_ok", 32'(frame_ok), 32'd1);
        chk("done_px_cnt", 32'(frame_cnt), 32'd5);

        // 5: asynchronous reset mid-frame
        for (int i = 0; i < 3; i++) cyc(1, 16'hFFFF, 0);
        chk_write("pre_rst", 3'd2, 8'hFF);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_we", 32'(mem_we), 32'd0);
        chk("arst_addr", 32'(mem_addr), 32'd0);
        chk("arst_data", 32'(mem_data), 32'd0);
        chk("arst_cnt", 32'(frame_cnt), 32'd0);
        cyc(0, 16'h0, 0);
        @(negedge p_clock);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(1, 16'hFFFF, 0);
            chk("post_rst_we", 32'(mem_we), 32'd0);
            chk("post_rst_okerr", 32'({frame_ok, frame_err}), 32'd0);
        end
        cyc(0, 16'h0, 1);
        for (int i = 0; i < 8; i++) begin
            cyc(1, 16'hF800, 0);
            chk_write("resync", 3'(i), 8'hE0);
        end
        cyc(0, 16'h0, 1);
        cyc(0, 16'h0, 0);
        chk("resync_ok", 32'(frame_ok), 32'd1);
        chk("resync_cnt", 32'(frame_cnt), 32'd1);

`ifdef CAM_TEST_PATTERN_EN
        // 6: bar test pattern overrides camera data, indexed by column
        begin
            logic [7:0] bars [4] = '{8'hFF, 8'h1F, 8'hE3, 8'h03};
            test_en = 1'b1;
            for (int i = 0; i < 8; i++) begin
                cyc(1, 16'hF800, 0);
                chk_write("pattern", 3'(i), bars[i % 4]);
            end
            cyc(0, 16'h0, 1);
            cyc(0, 16'h0, 0);
            chk("pattern_ok", 32'(frame_ok), 32'd1);
            chk("pattern_cnt", 32'(frame_cnt), 32'd2);
            test_en = 1'b0;
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
